// File: rtl/map_row_reader_if.sv
// map_row_reader_if: word output stream of the map row reader (master drives, slave accepts)
//   out_valid : word held on out_data/out_row/out_last
//   out_ready : downstream accepts the word
//   out_data  : W packed cells, bit i = column (i mod W)
//   out_row   : row index of out_data
//   out_last  : final word of the scan
interface map_row_reader_if #(parameter int K = 7, parameter int W = 16);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [K-1:0] out_row;
  logic         out_last;
  modport master (output out_valid, out_data, out_row, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_last, output out_ready);
endinterface

// File: rtl/map_row_reader.sv
// map_row_reader: scans an N_ROWS x N_COLS 1-bit map and streams it as W-cell words
//   clk_envo, rst (async, active-high)
//   start     : request one full-map scan (ignored unless idle)
//   rAddrR/C  : map read address, read_data returns the cell one cycle later
//   hold_evo  : freezes map evolution during a scan; busy mirrors it
//   done      : one-cycle pulse after the final word is accepted
//   stream    : word output (map_row_reader_if master)
//   live_count: count of live cells in the scan, present only with MAP_SCAN_POPCOUNT_EN
module map_row_reader #(
  parameter int K      = 7,
  parameter int N_ROWS = 128,
  parameter int N_COLS = 128,
  parameter int W      = 16
) (
  input  logic                  clk_envo,
  input  logic                  rst,
  input  logic                  start,
  output logic [K-1:0]          rAddrR,
  output logic [K-1:0]          rAddrC,
  input  logic                  read_data,
  output logic                  hold_evo,
  output logic                  busy,
  output logic                  done,
  map_row_reader_if.master      stream
`ifdef MAP_SCAN_POPCOUNT_EN
  ,
  output logic [2*K:0]          live_count
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_EMIT, S_FIN} state_t;
  localparam logic [K:0] W_L    = (K+1)'(W);
  localparam logic [K:0] LAST_R = (K+1)'(N_ROWS - 1);
  localparam logic [K:0] END_C  = (K+1)'(N_COLS);
  state_t       state, nxt;
  logic [K:0]   row, col, row_nx, col_nx;
  logic [K-1:0] addr_r, addr_c;
  logic [W-1:0] data, sel;
  logic         word_end, last_word, accept;
  assign row_nx    = row + 1'b1;
  assign col_nx    = col + 1'b1;
  assign word_end  = (col % W_L) == W_L - 1'b1;
  // col has already advanced past the word when in EMIT, so the final word sits at END_C
  assign last_word = row == LAST_R && col == END_C;
  assign accept    = state == S_EMIT && stream.out_ready;
  always_comb begin
    sel = '0;
    for (int i = 0; i < W; i++) sel[i] = (col % W_L) == (K+1)'(i);
  end
  always_ff @(posedge clk_envo or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == S_IDLE ? (start ? S_READ : S_IDLE) :
          state == S_READ ? S_CAPT :
          state == S_CAPT ? (word_end ? S_EMIT : S_READ) :
          state == S_EMIT ? (stream.out_ready ? (last_word ? S_FIN : S_READ) : S_EMIT) :
          S_IDLE;
  end
  always_comb begin
    busy             = state != S_IDLE;
    hold_evo         = state != S_IDLE;
    done             = state == S_FIN;
    stream.out_valid = state == S_EMIT;
    stream.out_last  = state == S_EMIT && last_word;
    stream.out_data  = data;
    stream.out_row   = row[K-1:0];
    rAddrR           = addr_r;
    rAddrC           = addr_c;
  end
  // Addresses are only reloaded on transitions into READ so they stay frozen through EMIT/DONE/IDLE.
  always_ff @(posedge clk_envo or posedge rst) begin
    if (rst) begin
      row    <= '0;
      col    <= '0;
      addr_r <= '0;
      addr_c <= '0;
      data   <= '0;
`ifdef MAP_SCAN_POPCOUNT_EN
      live_count <= '0;
`endif
    end else if (state == S_IDLE && start) begin
      row    <= '0;
      col    <= '0;
      addr_r <= '0;
      addr_c <= '0;
`ifdef MAP_SCAN_POPCOUNT_EN
      live_count <= '0;
`endif
    end else if (state == S_CAPT) begin
      data <= (data & ~sel) | (sel & {W{read_data}});
      col  <= col_nx;
      if (!word_end) addr_c <= col_nx[K-1:0];
`ifdef MAP_SCAN_POPCOUNT_EN
      live_count <= live_count + {{(2*K){1'b0}}, read_data};
`endif
    end else if (accept && !last_word) begin
      if (col == END_C) begin
        col    <= '0;
        row    <= row_nx;
        addr_r <= row_nx[K-1:0];
        addr_c <= '0;
      end else begin
        addr_c <= col[K-1:0];
      end
    end
  end
endmodule

// File: tb/tb_map_row_reader.sv
// tb_map_row_reader: directed bench for map_row_reader (2x8 map W=4, plus 8x8 map W=8)
module tb_map_row_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, start2;
  logic [2:0] ar1, ac1, ar2, ac2;
  logic rd1, rd2, hold1, hold2, busy1, busy2, done1, done2;
`ifdef MAP_SCAN_POPCOUNT_EN
  logic [6:0] lc1, lc2;
`endif
  logic [7:0] map1 [8];
  logic [7:0] map2 [8];
  map_row_reader_if #(.K(3), .W(4)) s1 ();
  map_row_reader_if #(.K(3), .W(8)) s2 ();
  map_row_reader #(.K(3), .N_ROWS(2), .N_COLS(8), .W(4)) dut1 (
    .clk_envo(clk), .rst(rst), .start(start), .rAddrR(ar1), .rAddrC(ac1),
    .read_data(rd1), .hold_evo(hold1), .busy(busy1), .done(done1), .stream(s1)
`ifdef MAP_SCAN_POPCOUNT_EN
    , .live_count(lc1)
`endif
  );
  map_row_reader #(.K(3), .N_ROWS(8), .N_COLS(8), .W(8)) dut2 (
    .clk_envo(clk), .rst(rst), .start(start2), .rAddrR(ar2), .rAddrC(ac2),
    .read_data(rd2), .hold_evo(hold2), .busy(busy2), .done(done2), .stream(s2)
`ifdef MAP_SCAN_POPCOUNT_EN
    , .live_count(lc2)
`endif
  );
  assign s2.out_ready = 1'b1;
  always @(posedge clk) begin
    rd1 <= map1[ar1][ac1];
    rd2 <= map2[ar2][ac2];
  end
  int n_done1 = 0, n_words1 = 0;
  always @(posedge clk) begin
    if (done1) n_done1 <= n_done1 + 1;
    if (s1.out_valid && s1.out_ready) n_words1 <= n_words1 + 1;
  end
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_v(input bit second, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ((second ? s2.out_valid : s1.out_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  logic [3:0] exp1 [4];
  bit ok;
  int d0, w0;
  initial begin
    map1 = '{8'b1010_0011, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    map2 = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hF0, 8'h0F, 8'hAA, 8'h55};
    exp1 = '{4'b0011, 4'b1010, 4'b0000, 4'b0000};
    rst = 1'b1; start = 1'b0; start2 = 1'b0; s1.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_valid", s1.out_valid, 0);
    chk("rst_hold", hold1, 0);
    chk("rst_addr", {ar1, ac1}, 0);
    chk("rst_data", s1.out_data, 0);
    chk("rst_done", done1, 0);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy1, 1);
    chk("start_hold", hold1, 1);
    chk("start_addr", {ar1, ac1}, 0);
    d0 = n_done1; w0 = n_words1;
    wait_v(0, ok);
    chk("w0_valid", ok, 1);
    chk("w0_data", s1.out_data, 4'b0011);
    chk("w0_row", s1.out_row, 0);
    chk("w0_last", s1.out_last, 0);
    chk("w0_addr", {ar1, ac1}, 6'b000_011);
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", s1.out_valid, 1);
      chk("stall_data", s1.out_data, 4'b0011);
    end
    chk("stall_addr", {ar1, ac1}, 6'b000_011);
    s1.out_ready = 1'b1;
    for (int w = 1; w < 4; w++) begin
      @(negedge clk);
      start = 1'b0;
      wait_v(0, ok);
      chk("wn_valid", ok, 1);
      chk("wn_data", s1.out_data, exp1[w]);
      chk("wn_row", s1.out_row, w < 2 ? 0 : 1);
      chk("wn_last", s1.out_last, w == 3);
      if (w == 1) start = 1'b1;
    end
    @(negedge clk);
    chk("done_pulse", done1, 1);
    chk("done_busy", busy1, 1);
`ifdef MAP_SCAN_POPCOUNT_EN
    chk("pop_done", lc1, 4);
`endif
    @(negedge clk);
    chk("after_done", done1, 0);
    chk("after_busy", busy1, 0);
    chk("after_hold", hold1, 0);
`ifdef MAP_SCAN_POPCOUNT_EN
    chk("pop_stable", lc1, 4);
`endif
    repeat (20) @(negedge clk);
    chk("scan_words", n_words1 - w0, 4);
    chk("scan_dones", n_done1 - d0, 1);
    chk("no_restart", busy1, 0);
    s1.out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_v(0, ok);
    chk("r_w0_valid", ok, 1);
    s1.out_ready = 1'b1;
    @(negedge clk);
    s1.out_ready = 1'b0;
    wait_v(0, ok);
    chk("r_w1_valid", ok, 1);
    chk("r_w1_data", s1.out_data, 4'b1010);
    d0 = n_done1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy1, 0);
    chk("abort_valid", s1.out_valid, 0);
    chk("abort_hold", hold1, 0);
    chk("abort_addr", {ar1, ac1}, 0);
    chk("abort_data", s1.out_data, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", n_done1 - d0, 0);
    chk("abort_idle", busy1, 0);
    w0 = n_words1;
    s1.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (n_done1 - d0) == 1;
    end
    chk("restart_done", ok, 1);
    chk("restart_words", n_words1 - w0, 4);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int w = 0; w < 8; w++) begin
      wait_v(1, ok);
      chk("big_valid", ok, 1);
      chk("big_data", s2.out_data, map2[w]);
      chk("big_row", s2.out_row, w);
      chk("big_last", s2.out_last, w == 7);
      @(negedge clk);
    end
    chk("big_done", done2, 1);
`ifdef MAP_SCAN_POPCOUNT_EN
    chk("big_pop", lc2, 24);
`endif
    @(negedge clk);
    chk("big_idle", busy2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/map_row_reader.md
MAP_ROW_READER -- requirements
Module: map_row_reader

Interface
REQ-001 SHALL have parameter K, default 7: row/column address width.
REQ-002 SHALL have parameter N_ROWS, default 128: rows scanned, 1..2^K.
REQ-003 SHALL have parameter N_COLS, default 128: columns scanned, 1..2^K, integer multiple of W.
REQ-004 SHALL have parameter W, default 16: output word width in cells.
REQ-005 SHALL have port clk_envo, input, 1 bit: single clock, rising edge; reset is asynchronous and active-high.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request one full-map scan.
REQ-008 SHALL have port rAddrR, output, K bits: map read row address.
REQ-009 SHALL have port rAddrC, output, K bits: map read column address.
REQ-010 SHALL have port read_data, input, 1 bit: map cell value, valid one cycle after the address is presented.
REQ-011 SHALL have port hold_evo, output, 1 bit: freezes map evolution while high.
REQ-012 SHALL have port busy, output, 1 bit: a scan is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking scan completion.
REQ-014 SHALL have port out_valid, output, 1 bit: out_data holds a complete word.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-016 SHALL have port out_data, output, W bits: packed cells.
REQ-017 SHALL have port out_row, output, K bits: row index of out_data.
REQ-018 SHALL have port out_last, output, 1 bit: marks the final word of the scan.

Function
REQ-019 SHALL implement FSM IDLE -> READ -> CAPT -> (READ | EMIT) -> (READ | DONE) -> IDLE.
REQ-020 IDLE SHALL accept start=1 and enter READ at row 0, column 0, asserting busy and hold_evo from the next cycle.
REQ-021 READ SHALL drive the current row/column on rAddrR/rAddrC; CAPT SHALL store read_data into out_data bit (column mod W) and increment the column.
REQ-022 After CAPT, the FSM SHALL go to EMIT if (column mod W) was W-1; otherwise it SHALL return to READ, giving 2 cycles per cell.
REQ-023 EMIT SHALL hold out_valid=1 with out_data/out_row/out_last stable until the first cycle with out_ready=1.
REQ-024 On handshake, column SHALL wrap from N_COLS to 0 with row+1; after the word for row N_ROWS-1, column N_COLS-1, the FSM SHALL enter DONE.
REQ-025 out_last SHALL equal 1 only on the final word.
REQ-026 DONE SHALL pulse done=1 for exactly one cycle, then IDLE SHALL deassert busy and hold_evo.
REQ-027 start while not in IDLE SHALL be ignored; a scan SHALL never restart mid-frame.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 rAddrR/rAddrC SHALL hold their last value outside READ/CAPT.
REQ-030 Counters SHALL be K+1 bits wide so that N_COLS=2^K and N_ROWS=2^K terminate without overflow.

Reset
REQ-031 rst=1 SHALL force IDLE and zero all outputs and counters immediately, including mid-scan and mid-EMIT.
REQ-032 No done pulse SHALL follow an aborted scan.

Configuration
REQ-033 SHALL support macro MAP_SCAN_POPCOUNT_EN; when defined, it SHALL add output live_count[2K:0], cleared at scan start and incremented on each CAPT with read_data=1.
REQ-034 With MAP_SCAN_POPCOUNT_EN defined, live_count SHALL remain stable from done until the next accepted start.
REQ-035 Without MAP_SCAN_POPCOUNT_EN, the live_count port and its logic SHALL be absent.

Verification (K=3, N_ROWS=2, N_COLS=8, W=4)
REQ-036 Model with map row0=8'b1010_0011 and row1=0, start, out_ready=1 -> words 4'b0011 (row0), 4'b1010 (row0), 0, 0; out_last only on the 4th word; done one cycle after the 4th handshake.
REQ-037 Hold out_ready=0 for 10 cycles at the first EMIT -> out_valid stays 1 and out_data stays 4'b0011; no address change.
REQ-038 Pulse start again at the 2nd word -> the scan proceeds unchanged, and exactly 4 words and one done are produced.
REQ-039 Assert rst while in EMIT of the 2nd word -> next cycle busy=0, out_valid=0, hold_evo=0, addresses=0; no done; a new start yields a full 4-word scan.
REQ-040 Set N_ROWS=N_COLS=8, W=8 -> exactly 8 words, final word out_row=7, scan terminates.
REQ-041 With MAP_SCAN_POPCOUNT_EN defined on the REQ-036 map -> live_count=4 at done.
